// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and a one-entry MDU holding buffer,
// with a starvation counter that forces a buffer grant and a scoreboard of registers awaiting an MDU write.
module regfile_write_arbiter #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic              mdu_issue,
    input  logic [ADDR_W-1:0] mdu_issue_rd,
    output logic              reg_write,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic [31:0]       busy_mask
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {SRC_WB = 1'b0, SRC_MDU = 1'b1} src_t;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_rd;
    logic [DATA_W-1:0] buf_data;
    logic [CNT_W-1:0]  starve_cnt;
    src_t              out_src;

    logic              force_buf;
    logic              grant_wb;
    logic              grant_buf;
    logic [ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0] grant_data;
    logic [31:0]       busy_next;

    // Buffer is either empty and accepting, or full and waiting; it never loads and drains together.
    assign mdu_ready = !buf_valid;

    always_comb begin
        force_buf  = buf_valid && (starve_cnt == LIMIT);
        grant_buf  = force_buf || (!wb_valid && buf_valid);
        grant_wb   = !force_buf && wb_valid;
        wb_ready   = !force_buf;
        grant_rd   = grant_buf ? buf_rd : wb_rd;
        grant_data = grant_buf ? buf_data : wb_data;
    end

    // Clear on commit, then set on issue, so a re-issue to the same register stays busy.
    always_comb begin
        busy_next = busy_mask;
        if (reg_write && (out_src == SRC_MDU))
            busy_next[rd] = 1'b0;
        if (mdu_issue && (mdu_issue_rd != '0))
            busy_next[mdu_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid  <= 1'b0;
            buf_rd     <= '0;
            buf_data   <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_buf) begin
                buf_valid  <= 1'b0;
                starve_cnt <= '0;
            end else begin
                if (mdu_valid && !buf_valid) begin
                    buf_valid <= 1'b1;
                    buf_rd    <= mdu_rd;
                    buf_data  <= mdu_data;
                end
                if (buf_valid && grant_wb && (starve_cnt != LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
            out_src    <= SRC_WB;
            busy_mask  <= '0;
        end else begin
            busy_mask <= busy_next;
            if (grant_wb || grant_buf) begin
                // x0 writes still complete the handshake but never reach the register file.
                reg_write  <= (grant_rd != '0);
                rd         <= grant_rd;
                write_data <= grant_data;
                out_src    <= grant_buf ? SRC_MDU : SRC_WB;
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter with a transaction-level reference model and scoreboard.
module tb_regfile_write_arbiter;

    localparam int L = 3;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [63:0] mdu_data;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        reg_write;
    logic [4:0]  rd;
    logic [63:0] write_data;
    logic [31:0] busy_mask;

    regfile_write_arbiter #(
        .DATA_W(64), .ADDR_W(5), .STARVE_LIMIT(L), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .reg_write(reg_write), .rd(rd), .write_data(write_data), .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_ready;
        logic        mdu_ready;
        logic [31:0] busy;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: pending MDU results, lost-arbitration count, visible write port, pending registers.
    wr_t         m_buf[$];
    int          m_wait;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    logic [31:0] m_busy;
    logic        m_commit;
    logic [4:0]  m_commit_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_ready", {63'd0, wb_ready}, {63'd0, e.wb_ready});
            check("mdu_ready", {63'd0, mdu_ready}, {63'd0, e.mdu_ready});
            check("busy_mask", {32'd0, busy_mask}, {32'd0, e.busy});
            check("reg_write", {63'd0, reg_write}, {63'd0, e.we});
            check("rd", {59'd0, rd}, {59'd0, e.rd});
            check("write_data", write_data, e.data);
        end
    end

    task automatic model_reset();
        m_buf.delete();
        m_wait   = 0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        m_busy   = '0;
        m_commit = 1'b0;
        m_commit_rd = '0;
    endtask

    task automatic do_reset();
        wb_valid = 0; mdu_valid = 0; mdu_issue = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, record what the outputs must show this cycle, advance the model.
    task automatic cyc(input logic wv, input logic [4:0] wr, input logic [63:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [63:0] md,
                       input logic iv, input logic [4:0] ir);
        exp_t e;
        wr_t  w;
        logic full;
        logic starved;
        logic commit_n;
        full    = (m_buf.size() != 0);
        starved = full && (m_wait == L);

        wb_valid = wv; wb_rd = wr; wb_data = wd;
        mdu_valid = mv; mdu_rd = mr; mdu_data = md;
        mdu_issue = iv; mdu_issue_rd = ir;

        e.wb_ready  = !starved;
        e.mdu_ready = !full;
        e.busy      = m_busy;
        e.we        = m_we;
        e.rd        = m_rd;
        e.data      = m_data;
        exp_q.push_back(e);

        commit_n = 1'b0;
        if (starved || (!wv && full)) begin
            w = m_buf.pop_front();
            m_wait = 0;
            m_we = (w.rd != 0); m_rd = w.rd; m_data = w.data;
            commit_n = (w.rd != 0);
        end else if (wv) begin
            m_we = (wr != 0); m_rd = wr; m_data = wd;
            if (full && m_wait < L) m_wait++;
        end else begin
            m_we = 1'b0;
        end

        if (m_commit) m_busy[m_commit_rd] = 1'b0;
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        m_commit = commit_n;
        if (commit_n) m_commit_rd = w.rd;

        if (!full && mv) begin
            w.rd = mr; w.data = md;
            m_buf.push_back(w);
        end

        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        mdu_issue = 0; mdu_issue_rd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset with a full buffer and a busy bit set
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd4);
        cyc(1, 5'd2, 64'h11, 1, 5'd9, 64'h99, 0, 0);
        cyc(1, 5'd2, 64'h12, 0, 0, 0, 0, 0);
        do_reset();
        idle(2);

        // Idle port: issue then result to x5
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd5);
        cyc(0, 0, 0, 1, 5'd5, 64'h1234, 0, 0);
        idle(4);

        // Contention: WB held on x7 while buffer holds x9
        cyc(1, 5'd7, 64'h70, 1, 5'd9, 64'h90, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 5'd7, 64'h71 + 64'(i), 0, 0, 0, 0, 0);
        idle(3);

        // x0 writes from both sources
        cyc(1, 5'd0, 64'hFFFF, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5'd0, 64'hABCD, 0, 0);
        idle(3);

        // Scoreboard race on x12: re-issue lands on the clearing edge
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd12);
        cyc(0, 0, 0, 1, 5'd12, 64'hC1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd12);
        cyc(0, 0, 0, 1, 5'd12, 64'hC2, 0, 0);
        idle(4);

        // Simultaneous WB x3 and buffered x4
        cyc(0, 0, 0, 1, 5'd4, 64'h44, 0, 0);
        cyc(1, 5'd3, 64'h33, 0, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cyc($urandom_range(0, 99) < 65, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                $urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)));
        end
        idle(5);
        #10;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
